board_access_arbiter: RTL and testbench
=======================================

BOARD_ACCESS_ARBITER -- requirements
Module: board_access_arbiter

Interface
REQ-001 Parameters: none; grid fixed at 20 columns x 15 rows, 4-bit cell data, 300-entry single-port board RAM external to block.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 vga_req  in  1  read request from display path; vga_x in 5, vga_y in 5 cell coordinates.
REQ-005 vga_gnt  out  1  read accepted this cycle; vga_rdata out 4 cell data; vga_rvalid out 1 qualifies vga_rdata.
REQ-006 p_req  in  1  player write request; p_x in 5, p_y in 5, p_wdata in 4; p_gnt out 1 accepted this cycle.
REQ-007 s_req  in  1  spawn write request; s_x in 5, s_y in 5, s_wdata in 4; s_gnt out 1 accepted this cycle.
REQ-008 err  out  1  one-cycle pulse: granted request had out-of-range coordinates.
REQ-009 mem_addr out 9, mem_we out 1, mem_wdata out 4, mem_rdata in 4: RAM port, read data valid one cycle after address.
REQ-010 busy  out  1  high while clear sweep runs.

Function
REQ-011 States: CLEAR, RUN; only two states.
REQ-012 CLEAR: 9-bit counter 0..299; each cycle registers mem_addr=counter, mem_we=1, mem_wdata=0; all gnt=0; busy=1.
REQ-013 CLEAR -> RUN on the cycle counter=299 is issued; exactly 300 write cycles; counter never exceeds 299.
REQ-014 RUN: busy=0; arbitration combinational per cycle; at most one gnt high per cycle.
REQ-015 Priority: vga_req absolute highest; p_req/s_req round-robin via 1-bit last-winner pointer, pointer updates only on p or s grant.
REQ-016 Pointer resets to "spawn last" so player wins first simultaneous p/s contention.
REQ-017 gnt asserted in same cycle as req when selected; requester holds req/coords/data until gnt, drops at next edge; req still high after gnt = new request.
REQ-018 Address = y*20 + x, 9-bit unsigned, computed on granted requester's coordinates.
REQ-019 Granted cycle N: mem_addr/mem_we/mem_wdata registered at end of N, valid in N+1; mem_we=1 only for valid write grants.
REQ-020 Out-of-range (x>19 or y>14): gnt still issued, mem_we=0, err=1 in cycle N+1; VGA read out of range returns vga_rdata=0 with vga_rvalid.
REQ-021 VGA read: vga_rvalid=1 and vga_rdata=mem_rdata in cycle N+2; 2-stage valid pipeline; back-to-back VGA grants yield back-to-back rvalid.
REQ-022 Idle cycle (no grant, RUN): mem_we=0, mem_addr holds previous value.
REQ-023 Writes to the same cell by p and s in consecutive cycles: later grant's data persists; no merging.

Reset
REQ-024 rst at any time, including mid-CLEAR or mid-read: next cycle state=CLEAR, counter=0, pointer="spawn last", all gnt/err/vga_rvalid=0, vga_rdata=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=1 from the first post-reset cycle.
REQ-025 In-flight VGA read at reset discarded; no vga_rvalid produced for it.

Verification
REQ-026 Release rst -> busy=1 for 300 cycles, mem_we=1 with addr 0..299 sequential, wdata=0; then busy=0, no grants during sweep despite req high.
REQ-027 RUN, p_req x=3 y=2 wdata=5 -> p_gnt same cycle, next cycle mem_addr=43, mem_we=1, mem_wdata=5.
REQ-028 vga_req, p_req, s_req all high held -> vga wins each cycle; drop vga -> p wins, then s, then p (alternating).
REQ-029 vga_req x=19 y=14 after cell 299 written with 9 -> mem_addr=299 next cycle, vga_rvalid=1, vga_rdata=9 two cycles after grant.
REQ-030 s_req x=20 y=0 -> s_gnt=1, mem_we stays 0, err=1 for one cycle.
REQ-031 Assert rst at counter=150 -> sweep restarts from addr 0, full 300 cycles.

Source files
------------

// File: rtl/board_access_arbiter.sv
// Arbitrates one single-port 20x15 board RAM between a display reader and two writers,
// and clears the whole board with a write sweep after reset.
module board_access_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       vga_req,
    input  logic [4:0] vga_x,
    input  logic [4:0] vga_y,
    output logic       vga_gnt,
    output logic [3:0] vga_rdata,
    output logic       vga_rvalid,
    input  logic       p_req,
    input  logic [4:0] p_x,
    input  logic [4:0] p_y,
    input  logic [3:0] p_wdata,
    output logic       p_gnt,
    input  logic       s_req,
    input  logic [4:0] s_x,
    input  logic [4:0] s_y,
    input  logic [3:0] s_wdata,
    output logic       s_gnt,
    output logic       err,
    output logic [8:0] mem_addr,
    output logic       mem_we,
    output logic [3:0] mem_wdata,
    input  logic [3:0] mem_rdata,
    output logic       busy
);

    typedef enum logic {CLEAR, RUN} state_t;

    localparam logic [8:0] LAST_CELL = 9'd299;

    state_t     state, state_nxt;
    logic [8:0] cnt, cnt_nxt;
    logic       last_s, last_s_nxt;
    logic [8:0] addr_nxt;
    logic       we_nxt;
    logic [3:0] wdata_nxt;
    logic       err_nxt;
    logic       rd1, rd1_nxt, rd2;
    logic       oor1, oor1_nxt, oor2;
    logic [4:0] sel_x, sel_y;
    logic [3:0] sel_d;
    logic       in_range;
    logic [8:0] lin_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLEAR;
            cnt       <= '0;
            last_s    <= 1'b1;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            err       <= 1'b0;
            rd1       <= 1'b0;
            rd2       <= 1'b0;
            oor1      <= 1'b0;
            oor2      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            last_s    <= last_s_nxt;
            mem_addr  <= addr_nxt;
            mem_we    <= we_nxt;
            mem_wdata <= wdata_nxt;
            err       <= err_nxt;
            rd1       <= rd1_nxt;
            rd2       <= rd1;
            oor1      <= oor1_nxt;
            oor2      <= oor1;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        last_s_nxt = last_s;
        addr_nxt   = mem_addr;
        we_nxt     = 1'b0;
        wdata_nxt  = mem_wdata;
        err_nxt    = 1'b0;
        rd1_nxt    = 1'b0;
        oor1_nxt   = 1'b0;
        vga_gnt    = 1'b0;
        p_gnt      = 1'b0;
        s_gnt      = 1'b0;
        busy       = 1'b0;
        sel_x      = '0;
        sel_y      = '0;
        sel_d      = '0;

        case (state)
            CLEAR: begin
                busy      = 1'b1;
                addr_nxt  = cnt;
                we_nxt    = 1'b1;
                wdata_nxt = '0;
                if (cnt == LAST_CELL) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 9'd1;
                end
            end
            default: begin
                // p wins a p/s tie only when spawn held the last grant
                if (vga_req) begin
                    vga_gnt = 1'b1;
                    sel_x   = vga_x;
                    sel_y   = vga_y;
                end else if (p_req && (!s_req || last_s)) begin
                    p_gnt      = 1'b1;
                    last_s_nxt = 1'b0;
                    sel_x      = p_x;
                    sel_y      = p_y;
                    sel_d      = p_wdata;
                end else if (s_req) begin
                    s_gnt      = 1'b1;
                    last_s_nxt = 1'b1;
                    sel_x      = s_x;
                    sel_y      = s_y;
                    sel_d      = s_wdata;
                end
                if (vga_gnt || p_gnt || s_gnt) begin
                    err_nxt  = !in_range;
                    rd1_nxt  = vga_gnt;
                    oor1_nxt = !in_range;
                    if (in_range) begin
                        addr_nxt = lin_addr;
                        if (!vga_gnt) begin
                            we_nxt    = 1'b1;
                            wdata_nxt = sel_d;
                        end
                    end
                end
            end
        endcase
    end

    assign in_range = (sel_x < 5'd20) && (sel_y < 5'd15);
    // y*20 == y*16 + y*4
    assign lin_addr = ({4'b0, sel_y} << 4) + ({4'b0, sel_y} << 2) + {4'b0, sel_x};

    assign vga_rvalid = rd2;
    assign vga_rdata  = (rd2 && !oor2) ? mem_rdata : '0;

endmodule

// File: tb/tb_board_access_arbiter.sv
// Directed bench for board_access_arbiter with a behavioural single-port board RAM.
module tb_board_access_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       vga_req, p_req, s_req;
    logic [4:0] vga_x, vga_y, p_x, p_y, s_x, s_y;
    logic [3:0] p_wdata, s_wdata;
    logic       vga_gnt, p_gnt, s_gnt, vga_rvalid, err, busy, mem_we;
    logic [3:0] vga_rdata, mem_wdata, mem_rdata;
    logic [8:0] mem_addr;
    logic [3:0] ram [0:299];
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    board_access_arbiter dut (
        .clk(clk), .rst(rst),
        .vga_req(vga_req), .vga_x(vga_x), .vga_y(vga_y),
        .vga_gnt(vga_gnt), .vga_rdata(vga_rdata), .vga_rvalid(vga_rvalid),
        .p_req(p_req), .p_x(p_x), .p_y(p_y), .p_wdata(p_wdata), .p_gnt(p_gnt),
        .s_req(s_req), .s_x(s_x), .s_y(s_y), .s_wdata(s_wdata), .s_gnt(s_gnt),
        .err(err), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always @(posedge clk) begin
        if (mem_we && mem_addr < 9'd300) ram[mem_addr] <= mem_wdata;
        mem_rdata <= (mem_addr < 9'd300) ? ram[mem_addr] : 4'd0;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic all_req_high;
        vga_req = 1; vga_x = 0;  vga_y = 0;
        p_req = 1;   p_x = 1;    p_y = 0; p_wdata = 7;
        s_req = 1;   s_x = 2;    s_y = 0; s_wdata = 8;
    endtask

    task automatic check_reset_state(input string tag);
        checks++;
        if ({busy, vga_gnt, p_gnt, s_gnt, err, vga_rvalid, vga_rdata, mem_we, mem_addr, mem_wdata}
            !== {1'b1, 5'b0, 4'd0, 1'b0, 9'd0, 4'd0}) begin
            failures++;
            $display("FAIL %s got busy=%b gnt=%b%b%b err=%b rv=%b rd=%h we=%b addr=%0d wd=%h", tag,
                     busy, vga_gnt, p_gnt, s_gnt, err, vga_rvalid, vga_rdata, mem_we, mem_addr, mem_wdata);
        end
    endtask

    task automatic sweep_check(input int n);
        for (int k = 0; k < n; k++) begin
            checks++;
            if ({busy, vga_gnt, p_gnt, s_gnt} !== 4'b1000) begin
                failures++;
                $display("FAIL sweep_busy k=%0d got busy/gnt=%b exp=1000", k, {busy, vga_gnt, p_gnt, s_gnt});
            end
            if (k >= 1) begin
                checks++;
                if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 9'(k - 1), 4'd0}) begin
                    failures++;
                    $display("FAIL sweep_write k=%0d got we=%b addr=%0d wd=%h exp we=1 addr=%0d wd=0",
                             k, mem_we, mem_addr, mem_wdata, k - 1);
                end
            end
            tick();
        end
    endtask

    task automatic check_sweep_end;
        checks++;
        if ({busy, mem_we, mem_addr, mem_wdata} !== {1'b0, 1'b1, 9'd299, 4'd0}) begin
            failures++;
            $display("FAIL sweep_end got busy=%b we=%b addr=%0d exp busy=0 we=1 addr=299", busy, mem_we, mem_addr);
        end
    endtask

    task automatic test_reset;
        rst = 1;
        all_req_high();
        tick();
        tick();
        check_reset_state("reset_state");
        rst = 0;
    endtask

    task automatic test_sweep;
        sweep_check(300);
        check_sweep_end();
        checks++;
        if ({vga_gnt, p_gnt, s_gnt} !== 3'b100) begin
            failures++;
            $display("FAIL first_run_gnt got %b exp 100", {vga_gnt, p_gnt, s_gnt});
        end
    endtask

    task automatic test_priority;
        logic [2:0] exp_g [0:2];
        logic [8:0] exp_a [0:2];
        logic [3:0] exp_d [0:2];
        exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b000;
        exp_a[0] = 9'd1;   exp_a[1] = 9'd2;   exp_a[2] = 9'd1;
        exp_d[0] = 4'd7;   exp_d[1] = 4'd8;   exp_d[2] = 4'd7;
        tick();
        checks++;
        if ({vga_gnt, p_gnt, s_gnt} !== 3'b100) begin
            failures++;
            $display("FAIL prio_vga got %b exp 100", {vga_gnt, p_gnt, s_gnt});
        end
        vga_req = 0;
        #1;
        checks++;
        if ({vga_gnt, p_gnt, s_gnt} !== 3'b010) begin
            failures++;
            $display("FAIL prio_p_first got %b exp 010", {vga_gnt, p_gnt, s_gnt});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 2) begin
                p_req = 0;
                s_req = 0;
                #1;
            end
            checks++;
            if ({vga_gnt, p_gnt, s_gnt, mem_we, mem_addr, mem_wdata} !== {exp_g[i], 1'b1, exp_a[i], exp_d[i]}) begin
                failures++;
                $display("FAIL prio_rr i=%0d got gnt=%b we=%b addr=%0d wd=%0d exp gnt=%b we=1 addr=%0d wd=%0d",
                         i, {vga_gnt, p_gnt, s_gnt}, mem_we, mem_addr, mem_wdata, exp_g[i], exp_a[i], exp_d[i]);
            end
        end
        tick();
        checks++;
        if ({mem_we, mem_addr} !== {1'b0, 9'd1}) begin
            failures++;
            $display("FAIL idle_hold got we=%b addr=%0d exp we=0 addr=1", mem_we, mem_addr);
        end
    endtask

    task automatic test_write;
        p_req = 1; p_x = 3; p_y = 2; p_wdata = 5;
        #1;
        checks++;
        if ({vga_gnt, p_gnt, s_gnt} !== 3'b010) begin
            failures++;
            $display("FAIL write_gnt got %b exp 010", {vga_gnt, p_gnt, s_gnt});
        end
        tick();
        p_req = 0;
        checks++;
        if ({mem_we, mem_addr, mem_wdata, err} !== {1'b1, 9'd43, 4'd5, 1'b0}) begin
            failures++;
            $display("FAIL write_mem got we=%b addr=%0d wd=%0d err=%b exp 1/43/5/0", mem_we, mem_addr, mem_wdata, err);
        end
        tick();
        checks++;
        if ({mem_we, mem_addr} !== {1'b0, 9'd43}) begin
            failures++;
            $display("FAIL write_idle got we=%b addr=%0d exp we=0 addr=43", mem_we, mem_addr);
        end
    endtask

    task automatic test_same_cell;
        p_req = 1; p_x = 5; p_y = 5; p_wdata = 3;
        #1;
        checks++;
        if (p_gnt !== 1'b1) begin
            failures++;
            $display("FAIL same_p_gnt got %b exp 1", p_gnt);
        end
        tick();
        p_req = 0;
        s_req = 1; s_x = 5; s_y = 5; s_wdata = 4;
        #1;
        checks++;
        if ({s_gnt, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 9'd105, 4'd3}) begin
            failures++;
            $display("FAIL same_p_write got sg=%b we=%b addr=%0d wd=%0d exp 1/1/105/3", s_gnt, mem_we, mem_addr, mem_wdata);
        end
        tick();
        s_req = 0;
        checks++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 9'd105, 4'd4}) begin
            failures++;
            $display("FAIL same_s_write got we=%b addr=%0d wd=%0d exp 1/105/4", mem_we, mem_addr, mem_wdata);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        p_req = 1; p_x = 19; p_y = 14; p_wdata = 9;
        #1;
        tick();
        p_req = 0;
        checks++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 9'd299, 4'd9}) begin
            failures++;
            $display("FAIL corner_write got we=%b addr=%0d wd=%0d exp 1/299/9", mem_we, mem_addr, mem_wdata);
        end
        vga_req = 1; vga_x = 19; vga_y = 14;
        #1;
        checks++;
        if ({vga_gnt, p_gnt, s_gnt} !== 3'b100) begin
            failures++;
            $display("FAIL rd_gnt0 got %b exp 100", {vga_gnt, p_gnt, s_gnt});
        end
        tick();
        vga_x = 5; vga_y = 5;
        #1;
        checks++;
        if ({mem_we, mem_addr, vga_rvalid, vga_gnt} !== {1'b0, 9'd299, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL rd_addr got we=%b addr=%0d rv=%b gnt=%b exp 0/299/0/1", mem_we, mem_addr, vga_rvalid, vga_gnt);
        end
        tick();
        vga_req = 0;
        checks++;
        if ({vga_rvalid, vga_rdata, mem_addr} !== {1'b1, 4'd9, 9'd105}) begin
            failures++;
            $display("FAIL rd_data0 got rv=%b rd=%0d addr=%0d exp 1/9/105", vga_rvalid, vga_rdata, mem_addr);
        end
        tick();
        checks++;
        if ({vga_rvalid, vga_rdata} !== {1'b1, 4'd4}) begin
            failures++;
            $display("FAIL rd_data1 got rv=%b rd=%0d exp 1/4", vga_rvalid, vga_rdata);
        end
        tick();
        checks++;
        if (vga_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL rd_done got rv=%b exp 0", vga_rvalid);
        end
    endtask

    task automatic test_out_of_range;
        s_req = 1; s_x = 20; s_y = 0; s_wdata = 6;
        #1;
        checks++;
        if ({vga_gnt, p_gnt, s_gnt} !== 3'b001) begin
            failures++;
            $display("FAIL oor_s_gnt got %b exp 001", {vga_gnt, p_gnt, s_gnt});
        end
        tick();
        s_req = 0;
        checks++;
        if ({mem_we, err} !== 2'b01) begin
            failures++;
            $display("FAIL oor_s_err got we=%b err=%b exp we=0 err=1", mem_we, err);
        end
        tick();
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL oor_err_pulse got err=%b exp 0", err);
        end
        vga_req = 1; vga_x = 0; vga_y = 15;
        #1;
        tick();
        vga_req = 0;
        checks++;
        if ({mem_we, err, mem_addr} !== {1'b0, 1'b1, 9'd105}) begin
            failures++;
            $display("FAIL oor_vga_err got we=%b err=%b addr=%0d exp 0/1/105", mem_we, err, mem_addr);
        end
        tick();
        checks++;
        if ({vga_rvalid, vga_rdata, err} !== {1'b1, 4'd0, 1'b0}) begin
            failures++;
            $display("FAIL oor_vga_data got rv=%b rd=%0d err=%b exp 1/0/0", vga_rvalid, vga_rdata, err);
        end
        tick();
    endtask

    task automatic test_reset_mid;
        vga_req = 1; vga_x = 19; vga_y = 14;
        #1;
        tick();
        vga_req = 0;
        rst = 1;
        tick();
        check_reset_state("reset_mid_read");
        all_req_high();
        rst = 0;
        sweep_check(150);
        rst = 1;
        tick();
        check_reset_state("reset_mid_sweep");
        rst = 0;
        sweep_check(300);
        check_sweep_end();
    endtask

    initial begin
        rst = 1;
        vga_req = 0; vga_x = 0; vga_y = 0;
        p_req = 0; p_x = 0; p_y = 0; p_wdata = 0;
        s_req = 0; s_x = 0; s_y = 0; s_wdata = 0;
        test_reset();
        test_sweep();
        test_priority();
        test_write();
        test_same_cell();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
